// File: rtl/uart_tx_feeder.sv
// Word FIFO and loader for the 18-bit UART transmitter.
// Words are handed over through the ld_tx_data/tx_busy handshake, with an optional idle gap.
module uart_tx_feeder #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned GAP   = 0
) (
  input  logic                       txclk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       wr_en_i,
  input  logic                       clr_err_i,
  input  logic                       tx_busy_i,
  output logic                       ld_tx_data_o,
  output logic [WIDTH-1:0]           tx_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o,
  output logic                       tx_err_o,
  output logic                       idle_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);
  localparam logic [7:0] GapInit = 8'(GAP);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAck,
    StSend,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [7:0]       gap_q, gap_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             ld_q, ld_d;
  logic             overflow_q, overflow_d;
  logic             tx_err_q, tx_err_d;

  logic full, empty, push, pop, tx_err_set;

  assign full  = (level_q == LvlFull);
  assign empty = (level_q == '0);
  // Fullness is judged before the edge, so a pop in the same cycle never makes room.
  assign push  = wr_en_i & ~full;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge txclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    pop        = 1'b0;
    tx_err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !tx_busy_i) begin
          state_d = StLoad;
          pop     = 1'b1;
        end
      end
      StLoad: begin
        state_d = StAck;
      end
      StAck: begin
        if (tx_busy_i) begin
          state_d = StSend;
        end else begin
          // Transmitter never took the word; it is dropped, not retried.
          tx_err_set = 1'b1;
          if (GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = GapInit;
          end
        end
      end
      StSend: begin
        if (!tx_busy_i) begin
          if (GAP == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gap_d   = GapInit;
          end
        end
      end
      StGap: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) begin
          state_d = StIdle;
          gap_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        gap_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loader FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_data_d  = tx_data_q;
    ld_d       = 1'b0;
    overflow_d = (wr_en_i & full) | (overflow_q & ~clr_err_i);
    tx_err_d   = tx_err_set | (tx_err_q & ~clr_err_i);
    if (pop) begin
      tx_data_d = mem_q[rd_ptr_q];
      ld_d      = 1'b1;
    end
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q  <= '0;
      ld_q       <= 1'b0;
      overflow_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      ld_q       <= ld_d;
      overflow_q <= overflow_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign ld_tx_data_o = ld_q;
  assign tx_data_o    = tx_data_q;
  assign full_o       = full;
  assign empty_o      = empty;
  assign level_o      = level_q;
  assign overflow_o   = overflow_q;
  assign tx_err_o     = tx_err_q;
  assign idle_o       = empty & (state_q == StIdle);

  // Structural invariants of the handshake and the FIFO.
  a_ld_only_in_load : assert property (@(posedge txclk) disable iff (!reset_n)
    ld_q |-> (state_q == StLoad));
  a_level_bound : assert property (@(posedge txclk) disable iff (!reset_n)
    level_q <= LvlFull);
  a_no_pop_empty : assert property (@(posedge txclk) disable iff (!reset_n)
    pop |-> !empty);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: two instances (GAP 0 and 5) share one stimulus stream,
// each with its own transmitter model and a queue-based reference of the feeder's behaviour.
module tb_uart_tx_feeder;

  localparam int unsigned WIDTH = 18;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);

  logic             txclk   = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_en   = 1'b0;
  logic             clr_err = 1'b0;
  logic             hold_busy = 1'b0;  // external frame keeps tx_busy high
  logic             xmt_off   = 1'b0;  // transmitter held in reset, never asserts busy

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 txclk = ~txclk;
  always @(posedge txclk) cyc <= cyc + 1;

  task automatic check(input string name, input int gap, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (GAP=%0d) at cycle %0d: got 'h%0h, expected 'h%0h",
               name, gap, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned Gap = (g == 0) ? 0 : 5;

    logic             ld, busy, full, empty, ovf, err, idle;
    logic [WIDTH-1:0] txd;
    logic [LvlW-1:0]  lvl;
    logic             busy_at_edge;
    int               bcnt;

    uart_tx_feeder #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .GAP   (Gap)
    ) u_dut (
      .txclk        (txclk),
      .reset_n      (reset_n),
      .wr_data_i    (wr_data),
      .wr_en_i      (wr_en),
      .clr_err_i    (clr_err),
      .tx_busy_i    (busy),
      .ld_tx_data_o (ld),
      .tx_data_o    (txd),
      .full_o       (full),
      .empty_o      (empty),
      .level_o      (lvl),
      .overflow_o   (ovf),
      .tx_err_o     (err),
      .idle_o       (idle)
    );

    // Transmitter: busy from the edge after the load pulse for 20 cycles.
    assign busy = hold_busy | (bcnt != 0);
    always @(posedge txclk or negedge reset_n) begin
      if (!reset_n)             bcnt <= 0;
      else if (ld && !xmt_off)  bcnt <= 20;
      else if (bcnt != 0)       bcnt <= bcnt - 1;
    end
    always @(posedge txclk) busy_at_edge <= busy;

    // Reference: queue of accepted words; a load may happen once the feeder is idle again,
    // which is (frame length + Gap - 1) edges after the previous load.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_data;
    bit               m_ovf, m_err, m_pop, set_ovf, acc, set_err;
    int               idle_from, err_at;

    always begin
      @(posedge txclk);
      #1;
      if (!reset_n) begin
        q.delete();
        m_data    = '0;
        m_ovf     = 1'b0;
        m_err     = 1'b0;
        m_pop     = 1'b0;
        idle_from = cyc;
        err_at    = -1;
      end else begin
        m_pop   = (q.size() != 0) && (cyc - 1 >= idle_from) && !busy_at_edge;
        set_ovf = wr_en && (q.size() == DEPTH);
        acc     = wr_en && (q.size() < DEPTH);
        set_err = (cyc == err_at);
        if (m_pop) begin
          m_data    = q.pop_front();
          idle_from = cyc + (xmt_off ? 3 : 23) + Gap - 1;
          if (xmt_off) err_at = cyc + 2;
        end
        if (acc) q.push_back(wr_data);
        m_ovf = set_ovf | (m_ovf & !clr_err);
        m_err = set_err | (m_err & !clr_err);
      end
      check("ld_tx_data", Gap, 32'(ld), 32'(m_pop));
      check("tx_data", Gap, 32'(txd), 32'(m_data));
      check("level", Gap, 32'(lvl), 32'(q.size()));
      check("empty", Gap, 32'(empty), 32'(q.size() == 0));
      check("full", Gap, 32'(full), 32'(q.size() == DEPTH));
      check("overflow", Gap, 32'(ovf), 32'(m_ovf));
      check("tx_err", Gap, 32'(err), 32'(m_err));
      check("idle", Gap, 32'(idle), 32'((q.size() == 0) && (cyc >= idle_from)));
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic write(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge txclk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    @(negedge txclk);
    while (!(g_inst[0].idle && g_inst[1].idle && g_inst[0].bcnt == 0 && g_inst[1].bcnt == 0)) begin
      @(negedge txclk);
      n++;
      if (n > max_cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_idle %s: still busy after %0d cycles", tag, max_cyc);
        return;
      end
    end
    repeat (3) @(negedge txclk);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge txclk);
    reset_n = 1'b1;
    @(negedge txclk);

    // Reset mid-frame with three words still queued; nothing may be re-sent afterwards.
    for (int i = 0; i < 4; i++) write(WIDTH'($urandom));
    repeat (5) @(negedge txclk);
    reset_n = 1'b0;
    repeat (3) @(negedge txclk);
    reset_n = 1'b1;
    repeat (30) @(negedge txclk);

    // Single word.
    write(18'h2A5A5);
    wait_idle(100, "single");

    // Four back-to-back words.
    for (int i = 0; i < 4; i++) write(WIDTH'($urandom));
    wait_idle(200, "back_to_back");

    // Overflow while the line is held busy, then drain in order.
    hold_busy = 1'b1;
    @(negedge txclk);
    for (int i = 0; i < 9; i++) write(WIDTH'($urandom));
    repeat (2) @(negedge txclk);
    clr_err = 1'b1;
    @(negedge txclk);
    clr_err = 1'b0;
    hold_busy = 1'b0;
    wait_idle(400, "overflow_drain");

    // Transmitter never acknowledges: word dropped, error flagged, next word normal.
    xmt_off = 1'b1;
    write(WIDTH'($urandom));
    wait_idle(50, "tx_err");
    xmt_off = 1'b0;
    write(WIDTH'($urandom));
    wait_idle(100, "after_tx_err");
    clr_err = 1'b1;
    @(negedge txclk);
    clr_err = 1'b0;

    // Two words for the inter-frame gap spacing.
    write(WIDTH'($urandom));
    write(WIDTH'($urandom));
    wait_idle(100, "gap");

    // Random traffic, including bursts that overrun the FIFO.
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = WIDTH'($urandom);
      clr_err = ($urandom_range(0, 31) == 0);
      @(negedge txclk);
    end
    wr_en   = 1'b0;
    clr_err = 1'b0;
    wait_idle(2000, "random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
